mem_arbiter: RTL



---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_timer.sv | 35 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: FSM state encoding,
// port-select constants and a small byte-enable helper.
package arb_pkg;

  // Arbiter FSM states; the encoding is fixed so the state can be decoded externally.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Which requester owns the access currently in flight.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // Byte enables only mean something for stores; loads present an all-zero mask.
  function automatic logic [3:0] store_be(input logic we, input logic [3:0] be);
    return we ? be : 4'b0000;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Wait counter for a granted memory access. It clears on grant, counts the
// BUSY cycles without mem_ready, saturates at all-ones and flags expiry when
// the count reaches TIMEOUT (never when TIMEOUT is 0).
module arb_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] SAT   = {CW{1'b1}};

  logic [CW-1:0] count_r;

  // Saturating wait counter: cleared on grant, advanced on stalled BUSY cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != SAT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (TIMEOUT != 32'd0) && (count_r == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter. Data accesses win over instruction
// fetches when both are pending in IDLE; an access in flight always runs to
// completion (or timeout) before the other port is considered.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  state_t state_r;
  state_t state_nxt_s;
  port_t  port_s;
  logic   grant_i_s;
  logic   grant_d_s;
  logic   finish_s;
  logic   abort_s;
  logic   busy_s;
  logic   expired_s;
  logic   end_s;

  assign busy_s = (state_r == I_BUSY) || (state_r == D_BUSY);
  assign end_s  = finish_s || abort_s;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_i_s || grant_d_s),
    .en      (busy_s && !mem_ready),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic plus grant/completion strobes for the output registers.
  always_comb begin
    state_nxt_s = state_r;
    grant_i_s   = 1'b0;
    grant_d_s   = 1'b0;
    finish_s    = 1'b0;
    abort_s     = 1'b0;
    port_s      = PORT_I;
    case (state_r)
      IDLE: begin
        if (d_req) begin
          state_nxt_s = D_BUSY;
          grant_d_s   = 1'b1;
        end else if (i_req) begin
          state_nxt_s = I_BUSY;
          grant_i_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      I_BUSY, D_BUSY: begin
        port_s = (state_r == D_BUSY) ? PORT_D : PORT_I;
        if (mem_ready) begin
          state_nxt_s = DONE;
          finish_s    = 1'b1;
        end else if (expired_s) begin
          state_nxt_s = DONE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory-side request registers: loaded on grant, mem_req dropped on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0000_0000;
      mem_wdata <= 32'h0000_0000;
    end else if (grant_d_s) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_be    <= store_be(d_we, d_be);
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (grant_i_s) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= i_addr;
      mem_wdata <= 32'h0000_0000;
    end else if (end_s) begin
      mem_req   <= 1'b0;
    end else begin
      mem_req   <= mem_req;
    end
  end

  // Requester-side acks, error flag and read data; rdata holds outside the ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      i_rdata <= 32'h0000_0000;
      d_rdata <= 32'h0000_0000;
    end else begin
      i_ack   <= end_s && (port_s == PORT_I);
      d_ack   <= end_s && (port_s == PORT_D);
      bus_err <= abort_s;
      if (end_s && (port_s == PORT_I)) begin
        i_rdata <= abort_s ? 32'h0000_0000 : mem_rdata;
      end else begin
        i_rdata <= i_rdata;
      end
      if (end_s && (port_s == PORT_D)) begin
        d_rdata <= abort_s ? 32'h0000_0000 : mem_rdata;
      end else begin
        d_rdata <= d_rdata;
      end
    end
  end

  assign stall_if  = i_req & ~i_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule
